uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Synchronous receive FIFO sitting directly downstream of the UART receive module. It captures each received byte when the receiver's FIFO write strobe is asserted, and returns the full flag to the receiver. It buffers bytes for the host/bus read side, and provides level, threshold, overrun and (optionally) idle-timeout status for the interrupt logic.

Parameters:
DATA_W, 8, payload width in bits (matches the Rx payload)
ADDR_W, 4, address width; depth = 2**ADDR_W entries (16)
TO_CYCLES, 4096, glb_clk cycles of inactivity before the timeout flag (optional feature only)

Ports:
glb_clk  in  1  system clock, all logic on the rising edge
glb_rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear: empties the FIFO and clears overrun
UART_ctrl_FIFO_w_en  in  1  write strobe from the Rx module, one-cycle pulse per byte
UART_Rx_data_payload  in  DATA_W  received byte, valid while the write strobe is high
FIFO_ctrl_full  out  1  FIFO full, fed back to the Rx module
r_en  in  1  read request from the host side
rd_data  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: rd_data holds a newly popped byte
FIFO_ctrl_empty  out  1  FIFO empty
level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W
thresh  in  ADDR_W+1  interrupt threshold (static configuration)
thresh_irq  out  1  level >= thresh and thresh != 0
overrun  out  1  sticky: a write was dropped because the FIFO was full
ovr_clr  in  1  synchronous clear of overrun
timeout_irq  out  1  idle timeout (optional feature; tied 0 when compiled out)

Behaviour:
- Reset values (async, glb_rstn low):
  - wr_ptr = rd_ptr = 0, level = 0
  - FIFO_ctrl_empty = 1, FIFO_ctrl_full = 0
  - rd_data = 0, rd_valid = 0
  - overrun = 0, thresh_irq = 0, timeout_irq = 0
  - Storage contents are not reset.
- Pointers: ADDR_W bits each, wrapping modulo depth. level is kept as an explicit counter of width ADDR_W+1.
- Flag timing: FIFO_ctrl_full = (level == 2**ADDR_W) and FIFO_ctrl_empty = (level == 0). Both are decoded combinationally from the registered level, so they change in the cycle after the edge that updated level.
- Write accepted = w_en and (not full, or a read is accepted in the same cycle). An accepted write stores the payload at wr_ptr and increments wr_ptr.
- Read accepted = r_en and not empty. On an accepted read:
  - rd_data <= mem[rd_ptr] at the same edge, rd_ptr increments, rd_valid = 1 for the next cycle.
  - Read latency is one clock from r_en to rd_valid.
- Read while empty: ignored. rd_valid stays 0, rd_data holds its value, no error is flagged.
- Simultaneous read and write:
  - Non-empty (including full): both are accepted and level is unchanged.
  - Empty: the write is accepted, the read is ignored, level becomes 1. There is no fall-through.
- Overflow: write while full with no accepted read. The byte is discarded, pointers and level are unchanged, and overrun <= 1.
- Overrun is sticky. It is cleared by ovr_clr or flush. If ovr_clr and a new overflow occur in the same cycle, the set wins.
- thresh_irq is registered: it updates at the edge after level changes.
- flush has priority over w_en and r_en in the same cycle:
  - Pointers and level go to 0, overrun goes to 0, rd_valid goes to 0.
  - rd_data keeps its value.
- Reset mid-operation: asynchronous return to the reset values. Any in-flight byte is lost.
- Level arithmetic: +1 on write-only, -1 on read-only, 0 on both or neither. The counter can never exceed depth or go below 0.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter increments each cycle while the FIFO is non-empty and no write or read is accepted.
  - The counter resets to 0 on any accepted write, accepted read, flush, or whenever the FIFO is empty.
  - When the counter reaches TO_CYCLES-1, timeout_irq <= 1 and the counter saturates.
  - timeout_irq clears at the edge after any accepted read, flush, or empty FIFO.
  - Purpose: flag residual bytes that remain below the threshold.
- Undefined: the counter is absent and timeout_irq is constant 0.

Test Plan:
1. Reset, then write 0xDE, 0xDF, 0xE0 (one w_en pulse each) -> level=3, empty=0. Three r_en pulses -> rd_valid on 3 cycles with rd_data 0xDE, 0xDF, 0xE0, then empty=1, level=0.
2. 16 writes of 0x00..0x0F -> full=1, level=16. A 17th write of 0xAA -> overrun=1, level stays 16. Read all 16 -> data 0x00..0x0F in order, no 0xAA. ovr_clr -> overrun=0.
3. Full FIFO with w_en=1 (0x55) and r_en=1 in the same cycle -> rd_data=oldest byte, level stays 16, 0x55 is the last byte read after draining.
4. Empty FIFO with w_en (0x11) and r_en in the same cycle -> rd_valid=0, level=1. Next r_en -> rd_data=0x11.
5. thresh=4; write 4 bytes -> thresh_irq=1 one cycle after level reaches 4. Read 1 -> thresh_irq=0. With overrun=1, pulse flush alongside w_en -> level=0, empty=1, overrun=0.
6. (UART_RX_FIFO_TIMEOUT_EN, TO_CYCLES=32) Write 1 byte, then idle -> timeout_irq=1 after 32 idle cycles. r_en -> timeout_irq=0. Without the macro -> timeout_irq stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte FIFO between the UART receiver and the host read port.
// The receiver pushes one byte per FIFO write strobe and throttles itself on
// FIFO_ctrl_full. The host pops with r_en and gets the byte one clock later on
// rd_data, qualified by rd_valid. Status outputs feed the interrupt logic.
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter. Without it timeout_irq is tied to 0.
//
// Parameters
//   DATA_W    payload width in bits
//   ADDR_W    pointer width, depth = 2**ADDR_W
//   TO_CYCLES idle glb_clk cycles before timeout_irq (timeout build only)
//
// Ports
//   glb_clk               system clock, rising edge
//   glb_rstn              asynchronous active-low reset
//   flush                 synchronous clear of contents and overrun
//   UART_ctrl_FIFO_w_en   write strobe from the receiver
//   UART_Rx_data_payload  received byte, valid with the write strobe
//   FIFO_ctrl_full        FIFO full, back to the receiver
//   r_en                  host read request
//   rd_data               registered read data
//   rd_valid              one-cycle pulse, rd_data holds a fresh byte
//   FIFO_ctrl_empty       FIFO empty
//   level                 occupancy, 0..2**ADDR_W
//   thresh                interrupt threshold, 0 disables thresh_irq
//   thresh_irq            registered (level >= thresh) && thresh != 0
//   overrun               sticky, a byte was dropped while full
//   ovr_clr               synchronous clear of overrun
//   timeout_irq           idle timeout with residual bytes
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int TO_CYCLES = 4096
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              flush,
  input  logic              UART_ctrl_FIFO_w_en,
  input  logic [DATA_W-1:0] UART_Rx_data_payload,
  output logic              FIFO_ctrl_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              FIFO_ctrl_empty,
  output logic [ADDR_W:0]   level,
  input  logic [ADDR_W:0]   thresh,
  output logic              thresh_irq,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              timeout_irq
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LV = {1'b1, {ADDR_W{1'b0}}};

  // Occupancy update: +1 write-only, -1 read-only, unchanged otherwise.
  // Accept logic upstream guarantees the result stays within 0..DEPTH.
  function automatic logic [ADDR_W:0] level_next(input logic [ADDR_W:0] lv,
                                                 input logic            inc,
                                                 input logic            dec);
    logic [ADDR_W:0] res;
    res = lv;
    case ({inc, dec})
      2'b10:   res = lv + (ADDR_W+1)'(1);
      2'b01:   res = lv - (ADDR_W+1)'(1);
      default: res = lv;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic              overrun_q;
  logic              thresh_irq_q;

  assign full  = (level_q == DEPTH_LV);
  assign empty = (level_q == '0);

  // flush overrides both sides. A write into a full FIFO still goes in when
  // the same cycle pops a byte, since the pop frees the slot it needs.
  assign rd_acc = r_en & ~empty & ~flush;
  assign wr_acc = UART_ctrl_FIFO_w_en & ~flush & (~full | rd_acc);
  assign ovf    = UART_ctrl_FIFO_w_en & ~flush & full & ~rd_acc;

  // Storage: written only on accepted writes, never reset.
  always_ff @(posedge glb_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= UART_Rx_data_payload;
    end
  end

  // Pointers, level and sticky overrun.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      level_q <= level_next(level_q, wr_acc, rd_acc);
      // A new overflow beats a simultaneous clear.
      if (ovf) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // ---- stage p1: read data and its valid, one clock after r_en ----
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
    end
  end

  // rd_data holds across ignored reads and flush.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      rd_data_p1 <= '0;
    end else if (rd_acc) begin
      rd_data_p1 <= mem[rd_ptr];
    end
  end

  // Threshold flag is registered from the registered level, so it trails
  // a level change by one edge.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      thresh_irq_q <= 1'b0;
    end else begin
      thresh_irq_q <= (thresh != '0) && (level_q >= thresh);
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  // Idle counter stops at TO_LAST instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == TO_LAST) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] idle_cnt;
  logic        to_q;

  // The flag sets on the TO_CYCLES-th consecutive idle cycle with data
  // pending. A write restarts the count but leaves an already raised flag
  // alone; only draining activity (read, flush, empty) drops it.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      if (flush || wr_acc || rd_acc || empty) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= sat_inc(idle_cnt);
      end
      if (flush || rd_acc || empty) begin
        to_q <= 1'b0;
      end else if (!wr_acc && (idle_cnt == TO_LAST)) begin
        to_q <= 1'b1;
      end
    end
  end

  assign timeout_irq = to_q;
`else
  assign timeout_irq = 1'b0;
`endif

  assign FIFO_ctrl_full  = full;
  assign FIFO_ctrl_empty = empty;
  assign level           = level_q;
  assign rd_data         = rd_data_p1;
  assign rd_valid        = vld_p1;
  assign overrun         = overrun_q;
  assign thresh_irq      = thresh_irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed scenarios followed by a randomized phase, all compared against a
// queue-based reference model of the receive FIFO.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int TO_CYCLES = 32;
  localparam int DEPTH     = 16;

  logic              glb_clk;
  logic              glb_rstn;
  logic              flush;
  logic              UART_ctrl_FIFO_w_en;
  logic [DATA_W-1:0] UART_Rx_data_payload;
  logic              FIFO_ctrl_full;
  logic              r_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              FIFO_ctrl_empty;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   thresh;
  logic              thresh_irq;
  logic              overrun;
  logic              ovr_clr;
  logic              timeout_irq;

  uart_rx_fifo #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .glb_clk              (glb_clk),
    .glb_rstn             (glb_rstn),
    .flush                (flush),
    .UART_ctrl_FIFO_w_en  (UART_ctrl_FIFO_w_en),
    .UART_Rx_data_payload (UART_Rx_data_payload),
    .FIFO_ctrl_full       (FIFO_ctrl_full),
    .r_en                 (r_en),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid),
    .FIFO_ctrl_empty      (FIFO_ctrl_empty),
    .level                (level),
    .thresh               (thresh),
    .thresh_irq           (thresh_irq),
    .overrun              (overrun),
    .ovr_clr              (ovr_clr),
    .timeout_irq          (timeout_irq)
  );

  initial glb_clk = 1'b0;
  always #5 glb_clk = ~glb_clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "reset";

  // Reference model state.
  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_vld;
  bit         m_ovr;
  bit         m_thr;
  bit         m_to;
  int         idle_run;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_BUILT = 1'b1;
`else
  localparam bit TO_BUILT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd     = 8'h00;
    m_vld    = 1'b0;
    m_ovr    = 1'b0;
    m_thr    = 1'b0;
    m_to     = 1'b0;
    idle_run = 0;
  endtask

  // One clock edge of the FIFO described at the transaction level.
  task automatic model_edge();
    int n;
    bit emp;
    bit ra;
    bit wa;
    n     = q.size();
    emp   = (n == 0);
    m_thr = (thresh != 0) && (n >= int'(thresh));
    if (flush) begin
      q.delete();
      m_ovr    = 1'b0;
      m_vld    = 1'b0;
      m_to     = 1'b0;
      idle_run = 0;
    end else begin
      ra    = r_en && !emp;
      wa    = UART_ctrl_FIFO_w_en && ((n < DEPTH) || ra);
      m_vld = ra;
      if (ra) m_rd = q.pop_front();
      if (wa) q.push_back(UART_Rx_data_payload);
      if (UART_ctrl_FIFO_w_en && !wa) m_ovr = 1'b1;
      else if (ovr_clr)               m_ovr = 1'b0;
      if (emp || ra || wa) idle_run = 0;
      else                 idle_run++;
      if (emp || ra)                     m_to = 1'b0;
      else if (idle_run >= TO_CYCLES)    m_to = 1'b1;
    end
  endtask

  task automatic check_all();
    check("level",       32'(level),           32'(q.size()));
    check("empty",       32'(FIFO_ctrl_empty), 32'(q.size() == 0));
    check("full",        32'(FIFO_ctrl_full),  32'(q.size() == DEPTH));
    check("rd_valid",    32'(rd_valid),        32'(m_vld));
    check("rd_data",     32'(rd_data),         32'(m_rd));
    check("overrun",     32'(overrun),         32'(m_ovr));
    check("thresh_irq",  32'(thresh_irq),      32'(m_thr));
    check("timeout_irq", 32'(timeout_irq),     32'(m_to && TO_BUILT));
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit fl = 1'b0, input bit oc = 1'b0);
    UART_ctrl_FIFO_w_en  = w;
    UART_Rx_data_payload = d;
    r_en                 = r;
    flush                = fl;
    ovr_clr              = oc;
    @(posedge glb_clk);
    model_edge();
    #1;
    check_all();
    UART_ctrl_FIFO_w_en  = 1'b0;
    UART_Rx_data_payload = 8'h00;
    r_en                 = 1'b0;
    flush                = 1'b0;
    ovr_clr              = 1'b0;
  endtask

  // Safety net against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] fill [DEPTH];
  int         pw;
  int         pr;

  initial begin
    glb_rstn             = 1'b0;
    flush                = 1'b0;
    UART_ctrl_FIFO_w_en  = 1'b0;
    UART_Rx_data_payload = 8'h00;
    r_en                 = 1'b0;
    ovr_clr              = 1'b0;
    thresh               = '0;
    model_reset();

    // Reset values.
    #3;
    check("rst_level",   32'(level),           32'd0);
    check("rst_empty",   32'(FIFO_ctrl_empty), 32'd1);
    check("rst_full",    32'(FIFO_ctrl_full),  32'd0);
    check("rst_rd_data", 32'(rd_data),         32'd0);
    check("rst_rd_vld",  32'(rd_valid),        32'd0);
    check("rst_overrun", 32'(overrun),         32'd0);
    check("rst_thr",     32'(thresh_irq),      32'd0);
    check("rst_to",      32'(timeout_irq),     32'd0);
    @(negedge glb_clk);
    glb_rstn = 1'b1;
    @(negedge glb_clk);

    // Three bytes in, three out, in order.
    phase = "t1";
    step(1, 8'hDE, 0);
    step(1, 8'hDF, 0);
    step(1, 8'hE0, 0);
    check("level3", 32'(level), 32'd3);
    step(0, 8'h00, 1);
    check("rd0", 32'(rd_data), 32'hDE);
    step(0, 8'h00, 1);
    check("rd1", 32'(rd_data), 32'hDF);
    step(0, 8'h00, 1);
    check("rd2", 32'(rd_data), 32'hE0);
    check("drained_empty", 32'(FIFO_ctrl_empty), 32'd1);
    step(0, 8'h00, 1);
    check("empty_read_no_vld", 32'(rd_valid), 32'd0);

    // Fill, overflow, drain, clear overrun.
    phase = "t2";
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    check("full16", 32'(FIFO_ctrl_full), 32'd1);
    step(1, 8'hAA, 0);
    check("ovr_set",   32'(overrun), 32'd1);
    check("ovr_level", 32'(level),   32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1);
      check("drain", 32'(rd_data), 32'(i));
    end
    step(0, 8'h00, 0, 0, 1);
    check("ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous read and write on a full FIFO.
    phase = "t3";
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 8'($urandom);
      step(1, fill[i], 0);
    end
    step(1, 8'h55, 1);
    check("rw_full_data",  32'(rd_data), 32'(fill[0]));
    check("rw_full_level", 32'(level),   32'd16);
    check("rw_full_novr",  32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
    check("last_is_55", 32'(rd_data), 32'h55);

    // Simultaneous read and write on an empty FIFO.
    phase = "t4";
    step(1, 8'h11, 1);
    check("rw_empty_vld",   32'(rd_valid), 32'd0);
    check("rw_empty_level", 32'(level),    32'd1);
    step(0, 8'h00, 1);
    check("rw_empty_data",  32'(rd_data),  32'h11);

    // Threshold and flush.
    phase = "t5";
    thresh = 5'd4;
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
    check("thr_lag", 32'(thresh_irq), 32'd0);
    step(0, 8'h00, 0);
    check("thr_set", 32'(thresh_irq), 32'd1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    check("thr_clr", 32'(thresh_irq), 32'd0);
    for (int i = 0; i < 14; i++) step(1, 8'($urandom), 0);
    check("t5_ovr", 32'(overrun), 32'd1);
    step(1, 8'h77, 0, 1, 0);
    check("flush_level", 32'(level),           32'd0);
    check("flush_empty", 32'(FIFO_ctrl_empty), 32'd1);
    check("flush_ovr",   32'(overrun),         32'd0);
    thresh = '0;

    // Idle timeout.
    phase = "t6";
    step(1, 8'h42, 0);
    for (int i = 0; i < TO_CYCLES - 1; i++) step(0, 8'h00, 0);
    check("to_before", 32'(timeout_irq), 32'd0);
    step(0, 8'h00, 0);
    check("to_after", 32'(timeout_irq), 32'(TO_BUILT));
    step(0, 8'h00, 1);
    check("to_read_clr", 32'(timeout_irq), 32'd0);

    // Asynchronous reset in the middle of traffic.
    phase = "t7";
    step(1, 8'h31, 0);
    step(1, 8'h32, 0);
    step(0, 8'h00, 1);
    #2;
    glb_rstn = 1'b0;
    #1;
    model_reset();
    check("arst_level",   32'(level),           32'd0);
    check("arst_empty",   32'(FIFO_ctrl_empty), 32'd1);
    check("arst_rd_data", 32'(rd_data),         32'd0);
    check("arst_vld",     32'(rd_valid),        32'd0);
    @(negedge glb_clk);
    glb_rstn = 1'b1;

    // Randomized traffic with varying read/write bias.
    phase = "rand";
    for (int blk = 0; blk < 8; blk++) begin
      pw     = (blk % 2 == 0) ? 75 : 30;
      pr     = (blk % 2 == 0) ? 30 : 75;
      thresh = 5'($urandom_range(0, DEPTH));
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(0, 99) < pw,
             8'($urandom),
             $urandom_range(0, 99) < pr,
             $urandom_range(0, 199) == 0,
             $urandom_range(0, 19) == 0);
      end
      // Idle stretch so the timeout path sees long gaps too.
      for (int c = 0; c < TO_CYCLES + 4; c++) step(0, 8'h00, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
